// File: rtl/jtag_master.sv
// JTAG master: walks the TAP state machine from command requests and returns captured TDO.
// Optional JTAG_MASTER_LOOPBACK_EN adds a loopback port that captures driven TDI instead of TDO.
module jtag_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [7:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
`ifdef JTAG_MASTER_LOOPBACK_EN
    input  logic               loopback,
`endif
    input  logic               TDO
);

    localparam int unsigned IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

    localparam logic [1:0] OpRst = 2'b00;
    localparam logic [1:0] OpIr  = 2'b01;
    localparam logic [1:0] OpDr  = 2'b10;
    localparam logic [1:0] OpRun = 2'b11;

    typedef enum logic [2:0] {
        StInitRst,
        StIdle,
        StRstSeq,
        StPre,
        StShift,
        StPost,
        StRun,
        StResp
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         bit_q, bit_d;
    logic [7:0]         div_q, div_d;
    logic [7:0]         len_q, len_d;
    logic [1:0]         op_q, op_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic               err_q, err_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               tdo_meta_q, tdo_sync_q;
    logic               sample;
    logic               len_bad;
    logic               bit_last;
    logic [7:0]         seq_len;

`ifdef JTAG_MASTER_LOOPBACK_EN
    assign sample = loopback ? tdi_q : tdo_sync_q;
`else
    assign sample = tdo_sync_q;
`endif

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = (state_q == StResp) ? cap_q : '0;
    assign rsp_err   = err_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

    always_comb begin
        len_bad = 1'b0;
        unique case (cmd_op)
            OpIr, OpDr: len_bad = (cmd_len == 8'd0) || ({24'd0, cmd_len} > MAX_LEN);
            OpRun:      len_bad = (cmd_len == 8'd0);
            default:    len_bad = 1'b0;
        endcase
    end

    // Number of TCK cycles spent in the current sequence state.
    always_comb begin
        seq_len = 8'd1;
        unique case (state_q)
            StInitRst, StRstSeq: seq_len = 8'd6;
            StPre:               seq_len = (op_q == OpIr) ? 8'd4 : 8'd3;
            StShift, StRun:      seq_len = len_q;
            StPost:              seq_len = 8'd2;
            default:             seq_len = 8'd1;
        endcase
    end

    assign bit_last = (bit_q == seq_len - 8'd1);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        div_d   = div_q;
        tck_d   = tck_q;
        op_d    = op_q;
        len_d   = len_q;
        data_d  = data_q;
        cap_d   = cap_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    len_d  = cmd_len;
                    data_d = cmd_data;
                    cap_d  = '0;
                    err_d  = 1'b0;
                    bit_d  = 8'd0;
                    div_d  = 8'd0;
                    tck_d  = 1'b0;
                    if (len_bad) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end else begin
                        unique case (cmd_op)
                            OpRst:      state_d = StRstSeq;
                            OpIr, OpDr: state_d = StPre;
                            default:    state_d = StRun;
                        endcase
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    cap_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else if (!tck_q) begin
                    tck_d = 1'b1;
                    div_d = 8'd0;
                end else begin
                    // Last CLK of the high phase: capture and step to the next bit.
                    tck_d = 1'b0;
                    div_d = 8'd0;
                    if (state_q == StShift) begin
                        cap_d[bit_q[IW-1:0]] = sample;
                    end
                    if (!bit_last) begin
                        bit_d = bit_q + 8'd1;
                    end else begin
                        bit_d = 8'd0;
                        unique case (state_q)
                            StInitRst: state_d = StIdle;
                            StPre:     state_d = StShift;
                            StShift:   state_d = StPost;
                            default:   state_d = StResp;
                        endcase
                    end
                end
            end
        endcase
    end

    // TMS/TDI follow the bit being entered, so they change only where a low phase starts.
    always_comb begin
        tms_d = 1'b0;
        tdi_d = 1'b0;
        unique case (state_d)
            StInitRst, StRstSeq: tms_d = (bit_d < 8'd5);
            StPre:   tms_d = (op_d == OpIr) ? (bit_d < 8'd2) : (bit_d == 8'd0);
            StShift: begin
                tms_d = (bit_d == len_d - 8'd1);
                tdi_d = data_d[bit_d[IW-1:0]];
            end
            StPost:  tms_d = (bit_d == 8'd0);
            default: begin
                tms_d = 1'b0;
                tdi_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StInitRst;
            bit_q   <= 8'd0;
            div_q   <= 8'd0;
            len_q   <= 8'd0;
            op_q    <= OpRst;
            data_q  <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            len_q   <= len_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tdo_meta_q <= 1'b0;
            tdo_sync_q <= 1'b0;
        end else begin
            tdo_meta_q <= TDO;
            tdo_sync_q <= tdo_meta_q;
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: vector table with scoreboard, a behavioural TAP target and
// hand-written sequences for response back-pressure and mid-command reset.
module tb_jtag_master;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned MAX_LEN    = 16;
    localparam logic [15:0] DR_CAPTURE = 16'hC3A5;

    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHD = 4, E1D = 5, PD = 6, E2D = 7;
    localparam int UDR = 8, SIR = 9, CIR = 10, SHI = 11, E1I = 12, PI = 13, E2I = 14, UIR = 15;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_len = 8'd0;
    logic [15:0] cmd_data = 16'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        TCK, TMS, TDI, TDO;
    logic        tdo_model = 1'b0;
    int          tdo_mode = 0;
`ifdef JTAG_MASTER_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    always #5 CLK = ~CLK;

    assign TDO = (tdo_mode == 2) ? tdo_model : (tdo_mode == 1);

    jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
`ifdef JTAG_MASTER_LOOPBACK_EN
        .loopback  (loopback),
`endif
        .TDO       (TDO)
    );

    // Behavioural TAP target: 4-bit IR capturing 0001, 16-bit DR capturing DR_CAPTURE.
    int          tap_st = TLR;
    logic [3:0]  ir_sr = 4'h0, ir_reg = 4'h0;
    logic [15:0] dr_sr = 16'h0, dr_reg = 16'h0;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDR : RTI;
            SDR: return m ? SIR : CDR;
            CDR: return m ? E1D : SHD;
            SHD: return m ? E1D : SHD;
            E1D: return m ? UDR : PD;
            PD:  return m ? E2D : PD;
            E2D: return m ? UDR : SHD;
            UDR: return m ? SDR : RTI;
            SIR: return m ? TLR : CIR;
            CIR: return m ? E1I : SHI;
            SHI: return m ? E1I : SHI;
            E1I: return m ? UIR : PI;
            PI:  return m ? E2I : PI;
            E2I: return m ? UIR : SHI;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge TCK) begin
        case (tap_st)
            CIR: ir_sr <= 4'b0001;
            SHI: ir_sr <= {TDI, ir_sr[3:1]};
            UIR: ir_reg <= ir_sr;
            CDR: dr_sr <= DR_CAPTURE;
            SHD: dr_sr <= {TDI, dr_sr[15:1]};
            UDR: dr_reg <= dr_sr;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, TMS);
    end

    always @(negedge TCK) begin
        tdo_model <= (tap_st == SHI) ? ir_sr[0] : (tap_st == SHD) ? dr_sr[0] : 1'b0;
    end

    // Pin history, one entry per TCK rising edge.
    int   tck_total = 0;
    logic tms_hist [0:4095];
    logic tdi_hist [0:4095];

    always @(posedge TCK) begin
        if (tck_total < 4096) begin
            tms_hist[tck_total] <= TMS;
            tdi_hist[tck_total] <= TDI;
        end
        tck_total <= tck_total + 1;
    end

    // High-phase width monitor.
    int unsigned high_run = 0;
    int          t_bad = 0, t_edges = 0;
    logic        prev_tck = 1'b0;
    logic        chk_timing = 1'b1;

    always @(negedge CLK) begin
        if (TCK) begin
            high_run <= high_run + 1;
        end else begin
            if (prev_tck && chk_timing) begin
                t_edges <= t_edges + 1;
                if (high_run != CLK_DIV) t_bad <= t_bad + 1;
            end
            high_run <= 0;
        end
        prev_tck <= TCK;
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  len;
        logic [15:0] data;
        int          tdo_mode;
        logic        lb;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_n;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          n;
        logic [63:0] tms;
        logic [63:0] tdi;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs [16];
    int   n_vec = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Expected pin patterns and latency, derived from the command alone.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int   pre;
        e.data = v.exp_data;
        e.err  = v.exp_err;
        e.n    = v.exp_err ? 0 : v.exp_n;
        e.tms  = '0;
        e.tdi  = '0;
        if (!v.exp_err) begin
            if (v.op == 2'b00) begin
                e.tms = 64'h1F;
            end else if (v.op != 2'b11) begin
                pre      = (v.op == 2'b01) ? 4 : 3;
                e.tms[0] = 1'b1;
                if (v.op == 2'b01) e.tms[1] = 1'b1;
                for (int i = 0; i < int'(v.len); i++) e.tdi[pre + i] = v.data[i];
                e.tms[pre + int'(v.len) - 1] = 1'b1;
                e.tms[pre + int'(v.len)]     = 1'b1;
            end
        end
        e.cyc = v.exp_err ? 1 : e.n * 2 * int'(CLK_DIV) + 1;
        return e;
    endfunction

    task automatic get_log(input int base, output int n, output logic [63:0] tms,
                           output logic [63:0] tdi);
        n   = tck_total - base;
        tms = '0;
        tdi = '0;
        for (int k = 0; k < 64; k++) begin
            if (k < n && base + k < 4096) begin
                tms[k] = tms_hist[base + k];
                tdi[k] = tdi_hist[base + k];
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t        e;
        int          cyc, base, n;
        logic [63:0] tms, tdi;
        @(negedge CLK);
        tdo_mode = v.tdo_mode;
`ifdef JTAG_MASTER_LOOPBACK_EN
        loopback = v.lb;
`endif
        sb.push_back(model(v));
        base      = tck_total;
        cmd_op    = v.op;
        cmd_len   = v.len;
        cmd_data  = v.data;
        cmd_valid = 1'b1;
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        check({tag, "_accept"}, 64'(cmd_ready), 64'd1);
        @(negedge CLK);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 5000) begin
            @(negedge CLK);
            cyc++;
        end
        e = sb.pop_front();
        get_log(base, n, tms, tdi);
        check({tag, "_latency"}, 64'(cyc), 64'(e.cyc));
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(e.data));
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(e.err));
        check({tag, "_busy"}, 64'(cmd_ready), 64'd0);
        check({tag, "_tck_count"}, 64'(n), 64'(e.n));
        check({tag, "_tms"}, tms, e.tms);
        check({tag, "_tdi"}, tdi, e.tdi);
        check({tag, "_tap_rti"}, 64'(tap_st), 64'(RTI));
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 64'({rsp_valid, cmd_ready}), 64'b01);
    endtask

    task automatic wait_init(input string tag);
        int cyc, bad, base, n;
        logic [63:0] tms, tdi;
        base = tck_total;
        @(negedge CLK);
        RST_N = 1'b1;
        cyc = 0;
        bad = 0;
        while (!cmd_ready && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
            if (rsp_valid) bad++;
        end
        get_log(base, n, tms, tdi);
        check({tag, "_latency"}, 64'(cyc), 64'(12 * CLK_DIV));
        check({tag, "_tck_count"}, 64'(n), 64'd6);
        check({tag, "_tms"}, tms, 64'h1F);
        check({tag, "_tdi"}, tdi, 64'h0);
        check({tag, "_no_rsp"}, 64'(bad), 64'd0);
        check({tag, "_tap_rti"}, 64'(tap_st), 64'(RTI));
    endtask

    initial begin
        int   cyc, bad, base;
        vec_t v;
        exp_t e;

        //          op     len     data     tdo lb  exp_data  err    n
        vecs[0]  = '{2'b10, 8'd9,   16'h00A5, 1, 0, 16'h01FF, 1'b0, 14};
        vecs[1]  = '{2'b01, 8'd4,   16'h0002, 2, 0, 16'h0001, 1'b0, 10};
        vecs[2]  = '{2'b10, 8'd0,   16'hFFFF, 1, 0, 16'h0000, 1'b1, 0};
        vecs[3]  = '{2'b10, 8'd17,  16'hFFFF, 1, 0, 16'h0000, 1'b1, 0};
        vecs[4]  = '{2'b01, 8'd17,  16'h1234, 1, 0, 16'h0000, 1'b1, 0};
        vecs[5]  = '{2'b11, 8'd0,   16'h0000, 1, 0, 16'h0000, 1'b1, 0};
        vecs[6]  = '{2'b11, 8'd5,   16'hFFFF, 1, 0, 16'h0000, 1'b0, 5};
        vecs[7]  = '{2'b00, 8'd0,   16'hFFFF, 1, 0, 16'h0000, 1'b0, 6};
        vecs[8]  = '{2'b10, 8'd16,  16'h1234, 2, 0, 16'hC3A5, 1'b0, 21};
        vecs[9]  = '{2'b10, 8'd5,   16'h001F, 2, 0, 16'h0005, 1'b0, 10};
        vecs[10] = '{2'b01, 8'd6,   16'h002F, 2, 0, 16'h0031, 1'b0, 12};
        vecs[11] = '{2'b10, 8'd1,   16'h0001, 1, 0, 16'h0001, 1'b0, 6};
        vecs[12] = '{2'b11, 8'd255, 16'h0000, 1, 0, 16'h0000, 1'b0, 255};
        vecs[13] = '{2'b10, 8'd16,  16'hFFFF, 0, 0, 16'h0000, 1'b0, 21};
        vecs[14] = '{2'b01, 8'd1,   16'h0000, 1, 0, 16'h0001, 1'b0, 7};
        vecs[15] = '{2'b01, 8'd16,  16'hFFFF, 1, 0, 16'hFFFF, 1'b0, 22};

        repeat (3) @(negedge CLK);
        check("reset_pins", 64'({TCK, TMS, TDI, cmd_ready, rsp_valid, rsp_err}), 64'b010000);
        check("reset_rsp_data", 64'(rsp_data), 64'h0);
        wait_init("init");

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            if (i == 0) check("v0_target_dr", 64'(dr_reg[15:7]), 64'h0A5);
            if (i == 1) check("v1_target_ir", 64'(ir_reg), 64'h2);
        end

        // Back-pressure: response held for 20 CLK with a competing command pending.
        @(negedge CLK);
        v = '{2'b11, 8'd3, 16'h0000, 1, 0, 16'h0000, 1'b0, 3};
        sb.push_back(model(v));
        base      = tck_total;
        cmd_op    = v.op;
        cmd_len   = v.len;
        cmd_data  = v.data;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 1000) begin
            @(negedge CLK);
            cyc++;
        end
        e = sb.pop_front();
        check("hold_latency", 64'(cyc), 64'(e.cyc));
        cmd_op    = 2'b00;
        cmd_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (!rsp_valid || cmd_ready || rsp_err || rsp_data != 16'h0) bad++;
            @(negedge CLK);
        end
        check("hold_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check("hold_release", 64'({rsp_valid, cmd_ready}), 64'b01);
        cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("hold_no_accept", 64'({cmd_ready, 32'(tck_total - base)}), {31'd0, 1'b1, 32'd3});

        // Reset asserted during shift bit 5 of a 16-bit DR scan.
        @(negedge CLK);
        tdo_mode  = 2;
        base      = tck_total;
        cmd_op    = 2'b10;
        cmd_len   = 8'd16;
        cmd_data  = 16'h5A5A;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cyc = 0;
        while (tck_total < base + 9 && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
        end
        check("abort_reached_bit5", 64'({TCK, 32'(tck_total - base)}), {31'd0, 1'b1, 32'd9});
        chk_timing = 1'b0;
        RST_N = 1'b0;
        #1;
        check("abort_pins", 64'({TCK, TMS, TDI, cmd_ready, rsp_valid, rsp_err}), 64'b010000);
        check("abort_rsp_data", 64'(rsp_data), 64'h0);
        repeat (2) @(negedge CLK);
        check("abort_held_pins", 64'({TCK, TMS, cmd_ready, rsp_valid}), 64'b0100);
        wait_init("reinit");
        chk_timing = 1'b1;
        run_vec(vecs[8], "post_abort");

`ifdef JTAG_MASTER_LOOPBACK_EN
        run_vec('{2'b10, 8'd16, 16'hBEEF, 0, 1, 16'hBEEF, 1'b0, 21}, "lb16");
        run_vec('{2'b10, 8'd5, 16'hBEEF, 0, 1, 16'h000F, 1'b0, 10}, "lb5");
        run_vec('{2'b10, 8'd16, 16'hBEEF, 0, 0, 16'h0000, 1'b0, 21}, "lb_off");
`endif

        check("tck_high_width", 64'(t_bad), 64'd0);
        check("tck_edges_seen", 64'(t_edges > 0), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
